// File: rtl/fpu_addsub_if.sv
// Start/ready handshake bundle for the fpu_addsub coprocessor.
// Operands and result are packed IEEE-754 words of 1+EXP_W+MAN_W bits.
interface fpu_addsub_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int DW = 1 + EXP_W + MAN_W;

    logic          start;
    logic          op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic          ready;
    logic          done;
    logic [DW-1:0] c;
    logic [3:0]    flags;

    modport master (output start, op, a, b, input ready, done, c, flags);
    modport slave  (input start, op, a, b, output ready, done, c, flags);
endinterface

// File: rtl/fpu_addsub.sv
// Multi-cycle IEEE-754 add/subtract with round-to-nearest-even and exception flags.
// Define FPU_DENORM_EN for subnormal support; otherwise subnormals flush to zero.
module fpu_addsub #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input logic         clk,
    input logic         rst,
    fpu_addsub_if.slave bus
);
    localparam int DW = 1 + EXP_W + MAN_W;
    localparam int W  = MAN_W + 5;   // {carry, hidden, fraction, G, R, S}
    localparam int EW = EXP_W + 1;   // headroom for carry past all-ones
    localparam logic [EXP_W-1:0] EMAX = '1;
    localparam logic [EW-1:0]    EMAX_W = {1'b0, EMAX};
    localparam logic [EW-1:0]    EONE = EW'(1);
    localparam logic [DW-1:0]    QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
`ifdef FPU_DENORM_EN
    localparam bit DENORM = 1'b1;
`else
    localparam bit DENORM = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, PACK} state_t;
    state_t state_reg, state_next;

    logic [DW-1:0] a_reg, b_reg;
    logic          op_reg;
    logic          sign_l_reg, sign_s_reg, sign_reg;
    logic [EW-1:0] exp_l_reg, exp_s_reg, exp_reg;
    logic [MAN_W:0] man_l_reg, man_s_reg;
    logic [W-1:0]  acc_l_reg, acc_s_reg, sum_reg;
    logic          bypass_reg;
    logic [DW-1:0] res_reg, c_reg;
    logic [3:0]    res_flags_reg, flags_reg;
    logic          done_reg;

    // Operand decode (valid while a_reg/b_reg hold the accepted operands)
    logic sa, sb, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero, special, a_big;
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic [EW-1:0]    a_exp, b_exp;
    logic [MAN_W:0]   a_man, b_man;
    logic [DW-1:0]    spec_res;
    logic [3:0]       spec_flags;

    always_comb begin
        sa = a_reg[DW-1];
        sb = b_reg[DW-1] ^ op_reg;
        ea = a_reg[DW-2:MAN_W];
        eb = b_reg[DW-2:MAN_W];
        fa = a_reg[MAN_W-1:0];
        fb = b_reg[MAN_W-1:0];
        a_nan  = (ea == EMAX) && (fa != '0);
        b_nan  = (eb == EMAX) && (fb != '0);
        a_snan = a_nan && !fa[MAN_W-1];
        b_snan = b_nan && !fb[MAN_W-1];
        a_inf  = (ea == EMAX) && (fa == '0);
        b_inf  = (eb == EMAX) && (fb == '0);
        a_zero = (ea == '0) && ((fa == '0) || !DENORM);
        b_zero = (eb == '0) && ((fb == '0) || !DENORM);
        a_exp  = (ea == '0) ? EONE : {1'b0, ea};
        b_exp  = (eb == '0) ? EONE : {1'b0, eb};
        a_man  = (ea != '0) ? {1'b1, fa} : (DENORM ? {1'b0, fa} : '0);
        b_man  = (eb != '0) ? {1'b1, fb} : (DENORM ? {1'b0, fb} : '0);
        a_big  = {a_exp, a_man} >= {b_exp, b_man};
        special = a_nan || b_nan || a_inf || b_inf || (a_zero && b_zero);

        spec_res   = {sa & sb, {(DW-1){1'b0}}};
        spec_flags = 4'b0000;
        if (a_nan || b_nan) begin
            spec_res   = QNAN;
            spec_flags = {a_snan || b_snan, 3'b000};
        end else if (a_inf && b_inf && (sa != sb)) begin
            spec_res   = QNAN;
            spec_flags = 4'b1000;
        end else if (a_inf) begin
            spec_res = {sa, EMAX, {MAN_W{1'b0}}};
        end else if (b_inf) begin
            spec_res = {sb, EMAX, {MAN_W{1'b0}}};
        end
    end

    // Alignment: shift the smaller mantissa right, folding lost bits into sticky
    logic [EW-1:0]  exp_diff, shamt;
    logic [2*W-1:0] wide;
    always_comb begin
        exp_diff = exp_l_reg - exp_s_reg;
        shamt    = (exp_diff > EW'(W)) ? EW'(W) : exp_diff;
        wide     = {1'b0, man_s_reg, 3'b000, {W{1'b0}}} >> shamt;
    end

    logic [W-1:0] sum_add;
    assign sum_add = (sign_l_reg == sign_s_reg) ? (acc_l_reg + acc_s_reg) : (acc_l_reg - acc_s_reg);

    logic norm_done;
    assign norm_done = sum_reg[W-1] || sum_reg[W-2] || (exp_reg == EONE);

    // Rounding and final assembly
    logic           g_bit, rs_bit, up, inexact;
    logic [MAN_W+1:0] rnd;
    logic [MAN_W:0] man_r;
    logic [EW-1:0]  exp_r;
    logic [DW-1:0]  fin_res;
    logic [3:0]     fin_flags;
    always_comb begin
        g_bit   = sum_reg[2];
        rs_bit  = sum_reg[1] | sum_reg[0];
        inexact = g_bit | rs_bit;
        up      = g_bit & (rs_bit | sum_reg[3]);
        rnd     = {1'b0, sum_reg[W-2:3]} + {{(MAN_W+1){1'b0}}, up};
        man_r   = rnd[MAN_W+1] ? rnd[MAN_W+1:1] : rnd[MAN_W:0];
        exp_r   = rnd[MAN_W+1] ? exp_reg + EONE : exp_reg;
        fin_res   = {sign_reg, exp_r[EXP_W-1:0], man_r[MAN_W-1:0]};
        fin_flags = {3'b000, inexact};
        if (exp_r >= EMAX_W) begin
            fin_res   = {sign_reg, EMAX, {MAN_W{1'b0}}};
            fin_flags = 4'b0101;
        end else if (!man_r[MAN_W]) begin
            if (DENORM) begin
                fin_res   = {sign_reg, {EXP_W{1'b0}}, man_r[MAN_W-1:0]};
                fin_flags = {2'b00, inexact, inexact};
            end else begin
                fin_res   = {sign_reg, {(DW-1){1'b0}}};
                fin_flags = 4'b0011;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    // Bypassed results pass through ROUND untouched, costing one cycle before PACK
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.start) state_next = UNPACK;
            UNPACK:  state_next = special ? ROUND : ALIGN;
            ALIGN:   state_next = ADD;
            ADD:     state_next = (sum_add == '0) ? ROUND : NORM;
            NORM:    if (norm_done) state_next = ROUND;
            ROUND:   state_next = PACK;
            PACK:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_reg <= '0; b_reg <= '0; op_reg <= 1'b0;
            sign_l_reg <= 1'b0; sign_s_reg <= 1'b0; sign_reg <= 1'b0;
            exp_l_reg <= '0; exp_s_reg <= '0; exp_reg <= '0;
            man_l_reg <= '0; man_s_reg <= '0;
            acc_l_reg <= '0; acc_s_reg <= '0; sum_reg <= '0;
            bypass_reg <= 1'b0; res_reg <= '0; res_flags_reg <= '0;
            c_reg <= '0; flags_reg <= '0; done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: if (bus.start) begin
                    a_reg <= bus.a; b_reg <= bus.b; op_reg <= bus.op;
                    bypass_reg <= 1'b0;
                end
                UNPACK: begin
                    bypass_reg    <= special;
                    res_reg       <= spec_res;
                    res_flags_reg <= spec_flags;
                    sign_l_reg <= a_big ? sa : sb;
                    sign_s_reg <= a_big ? sb : sa;
                    exp_l_reg  <= a_big ? a_exp : b_exp;
                    exp_s_reg  <= a_big ? b_exp : a_exp;
                    man_l_reg  <= a_big ? a_man : b_man;
                    man_s_reg  <= a_big ? b_man : a_man;
                end
                ALIGN: begin
                    acc_l_reg <= {1'b0, man_l_reg, 3'b000};
                    acc_s_reg <= wide[2*W-1:W] | {{(W-1){1'b0}}, |wide[W-1:0]};
                end
                ADD: begin
                    sum_reg  <= sum_add;
                    exp_reg  <= exp_l_reg;
                    sign_reg <= sign_l_reg;
                    if (sum_add == '0) begin
                        bypass_reg    <= 1'b1;
                        res_reg       <= '0;
                        res_flags_reg <= '0;
                    end
                end
                NORM: begin
                    if (sum_reg[W-1]) begin
                        sum_reg <= {1'b0, sum_reg[W-1:2], sum_reg[1] | sum_reg[0]};
                        exp_reg <= exp_reg + EONE;
                    end else if (!norm_done) begin
                        sum_reg <= sum_reg << 1;
                        exp_reg <= exp_reg - EONE;
                    end
                end
                ROUND: if (!bypass_reg) begin
                    res_reg       <= fin_res;
                    res_flags_reg <= fin_flags;
                end
                PACK: begin
                    c_reg     <= res_reg;
                    flags_reg <= res_flags_reg;
                    done_reg  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.ready = (state_reg == IDLE);
    assign bus.done  = done_reg;
    assign bus.c     = c_reg;
    assign bus.flags = flags_reg;
endmodule

// File: tb/tb_fpu_addsub.sv
// Directed single-precision vectors for fpu_addsub with hand-computed results and latencies.
module tb_fpu_addsub;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    fpu_addsub_if #(.EXP_W(8), .MAN_W(23)) bus ();

    fpu_addsub #(.EXP_W(8), .MAN_W(23)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_vec++;
        assert (got === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp_v);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic op, input logic [31:0] exp_c, input logic [3:0] exp_f,
                          input int exp_lat, input bit poke);
        int cyc;
        @(posedge clk); #1;
        chk({tag, "_ready_idle"}, {31'b0, bus.ready}, 32'd1);
        bus.a = a; bus.b = b; bus.op = op; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk({tag, "_ready_busy"}, {31'b0, bus.ready}, 32'd0);
        cyc = 0;
        if (poke) begin
            bus.a = 32'hDEADBEEF; bus.b = 32'h12345678; bus.start = 1'b1;
            @(posedge clk); #1;
            cyc++;
            bus.start = 1'b0;
        end
        while (!bus.done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, "_latency"}, cyc, exp_lat);
        chk({tag, "_c"}, bus.c, exp_c);
        chk({tag, "_flags"}, {28'b0, bus.flags}, {28'b0, exp_f});
        chk({tag, "_ready_done"}, {31'b0, bus.ready}, 32'd1);
        @(posedge clk); #1;
        chk({tag, "_done_pulse"}, {31'b0, bus.done}, 32'd0);
        $display("op %s: a=%h b=%h op=%0d -> c=%h flags=%b after %0d cycles",
                 tag, a, b, op, bus.c, bus.flags, cyc);
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", {31'b0, bus.ready}, 32'd1);
        chk("rst_done",  {31'b0, bus.done},  32'd0);
        chk("rst_c",     bus.c,              32'd0);
        chk("rst_flags", {28'b0, bus.flags}, 32'd0);
        rst = 1'b1;

        run_op("one_plus_two",  32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 6, 1'b0);
        run_op("busy_start_ign", 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 6, 1'b1);
        run_op("cancel_l24",    32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h33800000, 4'b0000, 30, 1'b0);
        run_op("inf_minus_inf", 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000, 3, 1'b0);
        run_op("overflow",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, 6, 1'b0);
        run_op("tie_even",      32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, 6, 1'b0);
        run_op("tie_odd_up",    32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001, 6, 1'b0);
        run_op("two_minus_one", 32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 4'b0000, 7, 1'b0);
        run_op("neg_result",    32'hBFC00000, 32'h3F000000, 1'b0, 32'hBF800000, 4'b0000, 6, 1'b0);
        run_op("exact_cancel",  32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, 5, 1'b0);
        run_op("negzero_sum",   32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, 3, 1'b0);
        run_op("qnan_in",       32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000, 3, 1'b0);
        run_op("snan_in",       32'h3F800000, 32'h7F800001, 1'b0, 32'h7FC00000, 4'b1000, 3, 1'b0);
        run_op("inf_plus_fin",  32'hFF800000, 32'h3F800000, 1'b1, 32'hFF800000, 4'b0000, 3, 1'b0);
`ifdef FPU_DENORM_EN
        run_op("denorm_add",    32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 4'b0000, 6, 1'b0);
        run_op("tiny_diff",     32'h00800001, 32'h00800000, 1'b1, 32'h00000001, 4'b0000, 6, 1'b0);
`else
        run_op("denorm_add",    32'h00000001, 32'h00000001, 1'b0, 32'h00000000, 4'b0000, 3, 1'b0);
        run_op("tiny_diff",     32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011, 6, 1'b0);
`endif

        // Reset in the middle of an operation
        @(posedge clk); #1;
        bus.a = 32'h3F800000; bus.b = 32'h40000000; bus.op = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("midrst_ready", {31'b0, bus.ready}, 32'd1);
        chk("midrst_done",  {31'b0, bus.done},  32'd0);
        chk("midrst_c",     bus.c,              32'd0);
        chk("midrst_flags", {28'b0, bus.flags}, 32'd0);
        $display("op mid_reset: ready=%0d done=%0d c=%h flags=%b",
                 bus.ready, bus.done, bus.c, bus.flags);
        @(posedge clk); #1;
        rst = 1'b1;

        run_op("after_reset",   32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 4'b0000, 6, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
